// File: rtl/conv_window_buffer.sv
// Sliding FxF window builder for a raster pixel stream. Line buffers feed the
// right column of a shift window; each complete patch is held until consumed.
module conv_window_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned F          = 3,
  parameter int unsigned IMG_W      = 8,
  parameter int unsigned IMG_H      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         pix_data,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  output logic [F*F*DATA_WIDTH-1:0]     win_data,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [$clog2(IMG_W)-1:0]      win_x,
  output logic [$clog2(IMG_H)-1:0]      win_y,
  output logic                          frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  typedef logic [DATA_WIDTH-1:0] pix_t;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] x_q, x_d;
  logic [RW-1:0] y_q, y_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  // lb_q[0] holds the previous row, lb_q[F-2] the oldest one.
  pix_t lb_q  [F-1][IMG_W];
  pix_t lb_d  [F-1][IMG_W];
  pix_t win_q [F][F];
  pix_t win_d [F][F];
  pix_t new_col [F];

  logic accept, consume, last_col, last_row, emit;

  assign pix_ready = reset & (~valid_q | win_ready);
  assign accept    = pix_valid & pix_ready;
  assign consume   = valid_q & win_ready;
  assign last_col  = (col_q == CW'(IMG_W - 1));
  assign last_row  = (row_q == RW'(IMG_H - 1));
  assign emit      = accept && (32'(row_q) >= F - 1) && (32'(col_q) >= F - 1);

  // Incoming column, oldest row on top.
  for (genvar r = 0; r < F - 1; r++) begin : g_new_col
    assign new_col[r] = lb_q[F-2-r][col_q];
  end
  assign new_col[F-1] = pix_data;

  for (genvar r = 0; r < F; r++) begin : g_pack_r
    for (genvar c = 0; c < F; c++) begin : g_pack_c
      assign win_data[DATA_WIDTH*(r*F+c) +: DATA_WIDTH] = win_q[r][c];
    end
  end

  assign win_valid  = valid_q;
  assign win_x      = x_q;
  assign win_y      = y_q;
  assign frame_done = done_q;

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    x_d     = x_q;
    y_d     = y_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    lb_d    = lb_q;
    win_d   = win_q;

    if (consume) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      for (int unsigned r = 0; r < F; r++) begin
        for (int unsigned c = 0; c < F - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][F-1] = new_col[r];
      end

      lb_d[0][col_q] = pix_data;
      for (int unsigned k = 1; k < F - 1; k++) begin
        lb_d[k][col_q] = lb_q[k-1][col_q];
      end

      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d  = '0;
          done_d = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end

      // A completing accept overrides a same-cycle consume.
      if (emit) begin
        valid_d = 1'b1;
        x_d     = col_q - CW'(F - 1);
        y_d     = row_q - RW'(F - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q   <= '0;
      row_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned k = 0; k < F - 1; k++) begin
        for (int unsigned i = 0; i < IMG_W; i++) begin
          lb_q[k][i] <= '0;
        end
      end
      for (int unsigned r = 0; r < F; r++) begin
        for (int unsigned c = 0; c < F; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      lb_q    <= lb_d;
      win_q   <= win_d;
    end
  end

endmodule
